// File: rtl/bam_error_monitor.sv
// bam_error_monitor: accumulates error count, signed/absolute error distance and max error
// of an approximate multiplier against the exact product over a programmed sample run.
module bam_error_monitor #(
  parameter int WIDTH   = 8,
  parameter int SAMPLES = 10000,
  parameter int CNT_W   = 14,
  parameter int ACC_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   p_apprx,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [ACC_W-1:0]     sum_ed_abs,
  output logic [ACC_W-1:0]     sum_ed,
  output logic [2*WIDTH-1:0]   max_ed,
  output logic                 acc_ovf
);
  localparam int PW = 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_accepted;
  logic              r_v1;
  logic [PW-1:0]     r_exact, r_apprx;
  logic              w_accept, w_last, w_clear;
  logic signed [PW:0] w_ed;
  logic [PW-1:0]     w_abs;
  logic [ACC_W:0]    w_abs_sum;
  assign in_ready  = (r_state == RUN) && (r_accepted < CNT_W'(SAMPLES));
  assign busy      = (r_state == RUN) || (r_state == DRAIN);
  assign done      = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = w_accept && (r_accepted == CNT_W'(SAMPLES - 1));
  assign w_clear   = start && (r_state == IDLE || r_state == DONE);
  assign w_ed      = $signed({1'b0, r_exact}) - $signed({1'b0, r_apprx});
  assign w_abs     = w_ed[PW] ? PW'(-w_ed) : w_ed[PW-1:0];
  // one extra bit catches the carry that signals saturation
  assign w_abs_sum = {1'b0, sum_ed_abs} + (ACC_W + 1)'(w_abs);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = start ? RUN : r_state;
      RUN:        w_next = w_last ? DRAIN : RUN;
      DRAIN:      w_next = r_v1 ? DRAIN : DONE;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_accepted   <= '0;
      r_v1         <= 1'b0;
      r_exact      <= '0;
      r_apprx      <= '0;
      sample_count <= '0;
      err_count    <= '0;
      sum_ed_abs   <= '0;
      sum_ed       <= '0;
      max_ed       <= '0;
      acc_ovf      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_v1    <= w_accept;
      if (w_accept) begin
        r_exact <= a * b;
        r_apprx <= p_apprx;
      end
      if (w_clear) begin
        r_accepted   <= '0;
        sample_count <= '0;
        err_count    <= '0;
        sum_ed_abs   <= '0;
        sum_ed       <= '0;
        max_ed       <= '0;
        acc_ovf      <= 1'b0;
      end else begin
        if (w_accept) r_accepted <= r_accepted + 1'b1;
        if (r_v1) begin
          sample_count <= sample_count + 1'b1;
          err_count    <= err_count + CNT_W'(w_ed != 0);
          sum_ed       <= sum_ed + ACC_W'(w_ed);
          sum_ed_abs   <= w_abs_sum[ACC_W] ? '1 : w_abs_sum[ACC_W-1:0];
          if (w_abs_sum[ACC_W]) acc_ovf <= 1'b1;
          if (w_abs > max_ed) max_ed <= w_abs;
        end
      end
    end
  end
endmodule

// File: tb/tb_bam_error_monitor.sv
// tb_bam_error_monitor: several monitor instances with different run lengths and accumulator
// widths share one sample bus; expected run results are queued and checked when done rises.
module tb_bam_error_monitor;
  localparam int N = 6;
  typedef struct {
    logic [31:0] id, sc, ec, sabs, sed, mx, ovf;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] rst_n, st, ovf, rdy, bsy, dn, prev_dn;
  logic         vi;
  logic [7:0]   ai, bi;
  logic [15:0]  pi;
  logic [13:0]  sc [N];
  logic [13:0]  ec [N];
  logic [31:0]  sabs [N];
  logic [31:0]  sed [N];
  logic [15:0]  mx [N];
  exp_t q[$];
  int checks = 0, errors = 0, rdy_cnt0 = 0;
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int S  = g == 0 ? 16 : g == 1 ? 4 : g == 2 ? 2 : g == 3 ? 2 : g == 4 ? 10 : 1;
    localparam int AW = (g == 3) ? 16 : 32;
    logic [AW-1:0] w_sabs, w_sed;
    bam_error_monitor #(.SAMPLES(S), .ACC_W(AW)) u_dut (
      .clk(clk), .rst_n(rst_n[g]), .start(st[g]), .in_valid(vi), .in_ready(rdy[g]),
      .a(ai), .b(bi), .p_apprx(pi), .busy(bsy[g]), .done(dn[g]),
      .sample_count(sc[g]), .err_count(ec[g]), .sum_ed_abs(w_sabs), .sum_ed(w_sed),
      .max_ed(mx[g]), .acc_ovf(ovf[g]));
    assign sabs[g] = 32'(w_sabs);
    assign sed[g]  = 32'(w_sed);
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // scoreboard monitor: a rising done presents one run's results
  always @(negedge clk) begin
    if (rdy[0]) rdy_cnt0++;
    for (int g = 0; g < N; g++) begin
      if (dn[g] && !prev_dn[g]) begin
        if (q.size() == 0) chk($sformatf("unexpected done dut%0d", g), 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("run id dut%0d", g), 32'(g), e.id);
          chk($sformatf("sample_count dut%0d", g), 32'(sc[g]), e.sc);
          chk($sformatf("err_count dut%0d", g), 32'(ec[g]), e.ec);
          chk($sformatf("sum_ed_abs dut%0d", g), sabs[g], e.sabs);
          chk($sformatf("sum_ed dut%0d", g), sed[g], e.sed);
          chk($sformatf("max_ed dut%0d", g), 32'(mx[g]), e.mx);
          chk($sformatf("acc_ovf dut%0d", g), 32'(ovf[g]), e.ovf);
        end
      end
    end
    prev_dn <= dn;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start(int id);
    st[id] = 1'b1;
    tick();
    st[id] = 1'b0;
  endtask
  task automatic expect_run(int id, logic [31:0] s, logic [31:0] e, logic [31:0] sa,
                            logic [31:0] sd, logic [31:0] m, logic [31:0] o);
    exp_t x;
    x.id = 32'(id); x.sc = s; x.ec = e; x.sabs = sa; x.sed = sd; x.mx = m; x.ovf = o;
    q.push_back(x);
  endtask
  task automatic send(int id, logic [7:0] a, logic [7:0] b, logic [15:0] p);
    int t = 0;
    ai = a; bi = b; pi = p; vi = 1'b1;
    @(negedge clk);
    while (!rdy[id] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[id]) chk($sformatf("in_ready timeout dut%0d", id), 32'd0, 32'd1);
    tick();
    vi = 1'b0;
  endtask
  // results must appear within two clocks of the final accept edge
  task automatic wait_done(int id);
    int t = 0;
    while (!dn[id] && t < 3) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("done latency dut%0d", id), 32'(dn[id]), 32'd1);
    tick();
  endtask
  task automatic chk_clear(int id, string tag);
    chk({tag, " sample_count"}, 32'(sc[id]), 32'd0);
    chk({tag, " err_count"}, 32'(ec[id]), 32'd0);
    chk({tag, " sum_ed_abs"}, sabs[id], 32'd0);
    chk({tag, " sum_ed"}, sed[id], 32'd0);
    chk({tag, " max_ed"}, 32'(mx[id]), 32'd0);
    chk({tag, " acc_ovf"}, 32'(ovf[id]), 32'd0);
    chk({tag, " busy"}, 32'(bsy[id]), 32'd0);
    chk({tag, " done"}, 32'(dn[id]), 32'd0);
    chk({tag, " in_ready"}, 32'(rdy[id]), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int x, y;
    rst_n = '0; st = '0; vi = 1'b0; ai = '0; bi = '0; pi = '0; prev_dn = '0;
    #12;
    chk_clear(0, "reset");
    rst_n = '1;
    tick();
    ai = 8'd5; bi = 8'd5; pi = 16'd0; vi = 1'b1;
    repeat (3) tick();
    vi = 1'b0;
    repeat (2) tick();
    for (int g = 0; g < N; g++) begin
      chk($sformatf("idle valid sample_count dut%0d", g), 32'(sc[g]), 32'd0);
      chk($sformatf("idle valid sum_ed_abs dut%0d", g), sabs[g], 32'd0);
    end
    pulse_start(0);
    expect_run(0, 16, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 255));
      send(0, 8'(x), 8'(y), 16'(x * y));
    end
    wait_done(0);
    chk("in_ready high cycles dut0", 32'(rdy_cnt0), 32'd16);
    pulse_start(1);
    expect_run(1, 4, 2, 8, 32'hFFFF_FFFE, 5, 0);
    send(1, 8'd10, 8'd10, 16'd97);
    tick();
    chk("bubble sample_count dut1", 32'(sc[1]), 32'd1);
    send(1, 8'd20, 8'd3, 16'd65);
    tick();
    chk("bubble sample_count2 dut1", 32'(sc[1]), 32'd2);
    send(1, 8'd7, 8'd7, 16'd49);
    tick();
    send(1, 8'd1, 8'd1, 16'd1);
    wait_done(1);
    ai = 8'd9; bi = 8'd9; pi = 16'd0; vi = 1'b1;
    repeat (3) tick();
    vi = 1'b0;
    tick();
    chk("done hold sample_count dut1", 32'(sc[1]), 32'd4);
    chk("done hold err_count dut1", 32'(ec[1]), 32'd2);
    chk("done hold done dut1", 32'(dn[1]), 32'd1);
    pulse_start(2);
    expect_run(2, 2, 2, 65535, 64515, 65025, 0);
    send(2, 8'd255, 8'd255, 16'd0);
    send(2, 8'd255, 8'd255, 16'd65535);
    wait_done(2);
    pulse_start(3);
    expect_run(3, 2, 2, 65535, 64514, 65025, 1);
    send(3, 8'd255, 8'd255, 16'd0);
    send(3, 8'd255, 8'd255, 16'd0);
    wait_done(3);
    pulse_start(3);
    chk("restart clears acc_ovf dut3", 32'(ovf[3]), 32'd0);
    chk("restart drops done dut3", 32'(dn[3]), 32'd0);
    expect_run(3, 2, 0, 0, 0, 0, 0);
    send(3, 8'd1, 8'd1, 16'd1);
    send(3, 8'd2, 8'd2, 16'd4);
    wait_done(3);
    pulse_start(5);
    expect_run(5, 1, 1, 1, 1, 1, 0);
    send(5, 8'd3, 8'd5, 16'd14);
    wait_done(5);
    pulse_start(4);
    for (int i = 0; i < 5; i++) send(4, 8'd1, 8'd1, 16'd2);
    tick();
    rst_n[4] = 1'b0;
    #1;
    chk_clear(4, "midrun reset");
    tick();
    rst_n[4] = 1'b1;
    tick();
    pulse_start(4);
    expect_run(4, 10, 1, 1000, 1000, 1000, 0);
    for (int i = 0; i < 9; i++) begin
      send(4, 8'(i + 1), 8'd3, 16'(3 * (i + 1)));
      if (i == 2) pulse_start(4);
      if (i % 2 == 1) tick();
    end
    send(4, 8'd200, 8'd200, 16'd39000);
    wait_done(4);
    repeat (3) tick();
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bam_error_monitor.md
Name: bam_error_monitor

Overview:
Hardware error-metric accumulator placed directly downstream of the 8-bit approximate multiplier (BAM_V8H2_Mult_8bits) on the characterisation path.
- Per sample, it takes the operands A, B and the approximate product P.
- It computes the exact product internally and accumulates error count, signed and absolute error distance, and maximum absolute error over a programmed number of samples.
- Software or an on-chip controller derives ER, MED, MNED and max from the outputs. No division is done in hardware.

Parameters:
WIDTH, 8, operand width; products are 2*WIDTH bits.
SAMPLES, 10000, samples accepted per run.
CNT_W, 14, width of sample and error counters; must satisfy 2^CNT_W > SAMPLES.
ACC_W, 32, width of the sum_ed_abs and sum_ed accumulators.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; clears results and begins a run.
in_valid  in  1  a, b, p_apprx are valid this cycle.
in_ready  out  1  block accepts a sample this cycle.
a  in  WIDTH  multiplicand fed to the multiplier.
b  in  WIDTH  multiplier operand.
p_apprx  in  2*WIDTH  approximate product from the multiplier.
busy  out  1  state is RUN or DRAIN.
done  out  1  state is DONE; results are stable.
sample_count  out  CNT_W  samples accumulated.
err_count  out  CNT_W  samples with exact != apprx.
sum_ed_abs  out  ACC_W  sum of |exact - apprx|, saturating.
sum_ed  out  ACC_W  signed sum of (exact - apprx), two's complement.
max_ed  out  2*WIDTH  largest |exact - apprx| seen.
acc_ovf  out  1  sticky flag: sum_ed_abs has saturated.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - Every output register clears to 0: sample_count, err_count, sum_ed_abs, sum_ed, max_ed, acc_ovf, done, busy, in_ready.
  - Both pipeline valid bits clear.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start: clear all result registers and the accepted-counter, then go to RUN. done drops on the next cycle.
  - RUN: in_ready = 1 while accepted < SAMPLES. A sample is accepted when in_valid && in_ready.
  - RUN -> DRAIN: on the cycle the SAMPLES-th sample is accepted. in_ready is 0 from the next cycle on.
  - DRAIN -> DONE: when both pipeline stages are empty.
  - DONE holds all results until the next start or reset.
- Ignored inputs:
  - start in RUN or DRAIN is ignored.
  - in_valid while in_ready = 0 is ignored, with no side effects.
- Pipeline (2 stages, fixed latency):
  - S1 (accept cycle +1) registers exact = a*b (2*WIDTH bits, unsigned) and apprx = p_apprx.
  - S2 (accept cycle +2) computes ed = exact - apprx as a (2*WIDTH+1)-bit signed value, and abs_ed = |ed|.
  - In the same S2 cycle: sample_count += 1; err_count += (ed != 0); sum_ed += sign-extended ed; sum_ed_abs += abs_ed; max_ed = abs_ed if abs_ed > max_ed (strictly greater).
  - Results are therefore visible 2 clocks after acceptance.
- Throughput: one sample per clock. Gaps in in_valid are bubbles that do not count.
- sum_ed_abs saturation: if the addition would exceed 2^ACC_W-1, hold at all-ones and set acc_ovf. acc_ovf clears only on start or reset.
- sum_ed wraps modulo 2^ACC_W. With the defaults it cannot wrap: 10000*65025 < 2^31.
- Counters never exceed SAMPLES, because acceptance stops at SAMPLES.
- done = 1 exactly when state is DONE. busy = 1 when state is RUN or DRAIN.
- SAMPLES = 1: the run goes RUN -> DRAIN on the first accept, then reaches DONE after the pipeline drains.
- Reset mid-run: any in-flight pipeline samples are discarded and everything returns to IDLE. No partial results are kept.

Test Plan:
- Exact source (SAMPLES=16, p_apprx = a*b, random a/b, in_valid=1) -> in_ready high 16 cycles; done within 2 cycles after the last accept; sample_count=16, err_count=0, sum_ed_abs=0, sum_ed=0, max_ed=0.
- SAMPLES=4, samples (10,10,97), (20,3,65), (7,7,49), (1,1,1) -> ED = +3, -5, 0, 0; err_count=2, sum_ed=-2, sum_ed_abs=8, max_ed=5.
- Worst case SAMPLES=2: (255,255,0) then (255,255,65535) -> ED = 65025, -510; max_ed=65025, sum_ed=64515, sum_ed_abs=65535, err_count=2.
- Saturation with ACC_W=16, SAMPLES=2, both (255,255,0) -> sum_ed_abs=65535, acc_ovf=1. A later start clears acc_ovf to 0.
- Handshake checks:
  - in_valid pulses in IDLE and DONE leave all counters at 0.
  - With in_valid toggling every other cycle, sample_count increments only on accepts.
  - start asserted during RUN has no effect.
- Reset mid-run (rst_n low 1 cycle after 5 of 10 samples) -> all outputs 0 immediately, state IDLE. A new start plus 10 samples gives sample_count=10.
